// File: rtl/card_row_fetch.sv
// Line-buffered reader for one horizontal row of cards: prefetches the next scan line during
// hblank over a single pixel-memory port, then plays it out against h_cnt. Optional CARD_BORDER_EN.
module card_row_fetch #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned ROW_X0   = 160,
  parameter int unsigned ROW_Y0   = 400,
  parameter int unsigned GAP      = 8,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic                 clk_25MHz,
  input  logic                 rst_n,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  input  logic [6*SLOTS-1:0]   card_types,
  output logic [5:0]           pixel_x,
  output logic [5:0]           pixel_y,
  output logic [5:0]           card_type,
  input  logic [11:0]          card_pixel,
  output logic [11:0]          pix_out,
  output logic                 pix_hit
);

  localparam int unsigned CARD_W  = 32;
  localparam int unsigned CARD_H  = 46;
  localparam int unsigned PITCH   = CARD_W + GAP;
  localparam int unsigned BUF_N   = SLOTS * CARD_W;
  localparam int unsigned KW      = $clog2(BUF_N);
  localparam int unsigned SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned V_BLANK = 480;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]         state;
  logic [KW-1:0]      k;
  logic [5:0]         row_q;
  logic [6*SLOTS-1:0] types_q;
  logic [SLOTS-1:0]   slot_valid;
  logic               wr_en_q;
  logic [KW-1:0]      wr_k_q;
  logic [11:0]        line_buf [BUF_N];

  // Next-line row decode for the fetch trigger
  logic [9:0]  nl;
  logic [10:0] row_d;
  logic        row_ok;
  logic        trigger;

  always_comb begin
    nl      = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    row_d   = {1'b0, nl} - 11'(ROW_Y0);
    row_ok  = !row_d[10] && (row_d <= 11'(CARD_H - 1));
    trigger = (state == IDLE) && (h_cnt == 10'(H_ACTIVE)) && row_ok;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      row_q      <= '0;
      types_q    <= '1;
      slot_valid <= '0;
      wr_en_q    <= 1'b0;
      wr_k_q     <= '0;
    end else begin
      wr_en_q <= (state == FETCH);
      wr_k_q  <= k;
      if (v_cnt == 10'(V_BLANK) && h_cnt == 10'd0) types_q <= card_types;
      case (state)
        IDLE: if (trigger) begin
          state      <= FETCH;
          k          <= '0;
          row_q      <= row_d[5:0];
          slot_valid <= '0;
        end
        FETCH: begin
          k <= k + 1'b1;
          if (k == KW'(BUF_N - 1)) state <= FLUSH;
        end
        FLUSH: begin
          // Empty slots were fetched like any other; they are masked here instead.
          for (int s = 0; s < SLOTS; s++) slot_valid[s] <= (types_q[6*s +: 6] <= 6'd53);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the line buffer is deliberately not reset; slot_valid masks stale contents.
  always_ff @(posedge clk_25MHz) begin
    if (wr_en_q) line_buf[wr_k_q] <= card_pixel;
  end

  logic [SW-1:0] k_slot;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    k_slot    = SW'(k >> 5);
    card_type = 6'd0;
    pixel_x   = 6'd0;
    pixel_y   = 6'd0;
    if (state == FETCH) begin
      card_type = types_q[6*k_slot +: 6];
      pixel_x   = {1'b0, k[4:0]};
      pixel_y   = row_q;
    end
  end

  // Playout decode: which slot/column h_cnt falls on, and whether v_cnt is a card line
  logic [10:0]   dx;
  logic [10:0]   dy;
  logic          y_in;
  logic          covered;
  logic [SW-1:0] slot_s;
  logic [4:0]    col;
  logic [KW-1:0] rd_idx;
  logic          hit_d;
`ifdef CARD_BORDER_EN
  logic          is_edge;
`endif

  always_comb begin
    dx      = {1'b0, h_cnt} - 11'(ROW_X0);
    dy      = {1'b0, v_cnt} - 11'(ROW_Y0);
    y_in    = !dy[10] && (dy <= 11'(CARD_H - 1));
    covered = 1'b0;
    slot_s  = '0;
    col     = '0;
    if (!dx[10]) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (dx >= 11'(s * PITCH) && dx < 11'(s * PITCH + CARD_W)) begin
          covered = 1'b1;
          slot_s  = SW'(s);
          col     = 5'(dx - 11'(s * PITCH));
        end
      end
    end
    rd_idx = KW'({slot_s, col});
    hit_d  = covered && y_in && slot_valid[slot_s];
`ifdef CARD_BORDER_EN
    is_edge = (col == 5'd0) || (col == 5'd31) || (dy == 11'd0) || (dy == 11'(CARD_H - 1));
`endif
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pix_out <= 12'h000;
      pix_hit <= 1'b0;
    end else if (covered) begin
      pix_hit <= hit_d;
`ifdef CARD_BORDER_EN
      pix_out <= (hit_d && is_edge) ? 12'hFFF : line_buf[rd_idx];
`else
      pix_out <= line_buf[rd_idx];
`endif
    end else begin
      pix_out <= 12'h000;
      pix_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_card_row_fetch.sv
// Randomized self-checking bench for card_row_fetch against a line-level behavioural model.
module tb_card_row_fetch;
  localparam int SLOTS = 4;

  logic              clk_25MHz = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        h_cnt = '0;
  logic [9:0]        v_cnt = '0;
  logic [6*SLOTS-1:0] card_types = '0;
  logic [5:0]        pixel_x, pixel_y, card_type;
  logic [11:0]       card_pixel = '0;
  logic [11:0]       pix_out;
  logic              pix_hit;

  card_row_fetch dut (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .card_types(card_types),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .card_type (card_type),
    .card_pixel(card_pixel),
    .pix_out   (pix_out),
    .pix_hit   (pix_hit)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  function automatic logic [11:0] mem_fn(int t, int x, int y);
    return 12'(t * 151 + x * 43 + y * 197 + ((t ^ x ^ y) << 7) + 1);
  endfunction

  // Pixel memory: one-cycle read latency
  always @(posedge clk_25MHz) card_pixel <= mem_fn(int'(card_type), int'(pixel_x), int'(pixel_y));

  int n_tests = 0;
  int n_fail  = 0;
  int cur_h, cur_v;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s v=%0d h=%0d got=%0h exp=%0h", tag, cur_v, cur_h, got, exp);
    end
  endtask

  // Reference state: shadowed types, the fetch in flight, and what the buffer holds
  int m_types[SLOTS];
  bit m_valid[SLOTS];
  int f_types[SLOTS];
  int b_types[SLOTS];
  int f_row, b_row;
  bit fetch_on;

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_types[s] = 63;
      m_valid[s] = 1'b0;
    end
    fetch_on = 1'b0;
  endtask

  task automatic cycle(int h, int v, bit rst_v);
    int dx, dy, s, c, i, nl;
    bit cov, exp_hit;
    logic [11:0] exp_out;
    int exp_t, exp_x, exp_y;
    @(negedge clk_25MHz);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    rst_n = rst_v;
    cur_h = h;
    cur_v = v;

    dx = h - 160;
    dy = v - 400;
    cov = 1'b0; s = 0; c = 0;
    if (dx >= 0 && dx / 40 < SLOTS && dx % 40 < 32) begin
      cov = 1'b1; s = dx / 40; c = dx % 40;
    end
    exp_hit = rst_v && cov && dy >= 0 && dy <= 45 && m_valid[s];
    exp_out = 12'h000;
    if (exp_hit) begin
      exp_out = mem_fn(b_types[s], c, b_row);
`ifdef CARD_BORDER_EN
      if (c == 0 || c == 31 || dy == 0 || dy == 45) exp_out = 12'hFFF;
`endif
    end

    if (!rst_v) model_reset();
    else begin
      if (v == 480 && h == 0)
        for (int j = 0; j < SLOTS; j++) m_types[j] = int'(card_types[6*j +: 6]);
      nl = (v == 524) ? 0 : v + 1;
      if (!fetch_on && h == 640 && nl >= 400 && nl <= 445) begin
        fetch_on = 1'b1;
        f_row = nl - 400;
        for (int j = 0; j < SLOTS; j++) begin
          f_types[j] = m_types[j];
          m_valid[j] = 1'b0;
        end
      end else if (fetch_on && h == 640 + 32 * SLOTS + 1) begin
        fetch_on = 1'b0;
        b_row = f_row;
        for (int j = 0; j < SLOTS; j++) begin
          b_types[j] = f_types[j];
          m_valid[j] = (f_types[j] <= 53);
        end
      end
    end

    exp_t = 0; exp_x = 0; exp_y = 0;
    i = h - 640;
    if (rst_v && fetch_on && i >= 0 && i < 32 * SLOTS) begin
      exp_t = f_types[i / 32]; exp_x = i % 32; exp_y = f_row;
    end

    @(posedge clk_25MHz);
    #1;
    check("pix_hit", 32'(pix_hit), 32'(exp_hit));
    if (!cov || !rst_v) check("pix_out_blank", 32'(pix_out), 32'h0);
    else if (exp_hit) check("pix_out", 32'(pix_out), 32'(exp_out));
    check("req_type", 32'(card_type), 32'(exp_t));
    check("req_x", 32'(pixel_x), 32'(exp_x));
    check("req_y", 32'(pixel_y), 32'(exp_y));
  endtask

  task automatic run_span(int v, int h0, int h1, bit rst_v);
    for (int h = h0; h <= h1; h++) cycle(h, v, rst_v);
  endtask

  task automatic run_line(int v);
    run_span(v, 0, 2, 1'b1);
    run_span(v, 150, 335, 1'b1);
    run_span(v, 636, 775, 1'b1);
  endtask

  task automatic rand_types(bit force_empty2, bit allow_empty);
    for (int s = 0; s < SLOTS; s++)
      card_types[6*s +: 6] = 6'(allow_empty ? $urandom_range(0, 63) : $urandom_range(0, 53));
    if (force_empty2) card_types[12 +: 6] = 6'd63;
  endtask

  initial begin
    #(40 * 95000);
    $display("FAIL timeout v=%0d h=%0d", cur_v, cur_h);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    b_row = 0;
    f_row = 0;
    for (int s = 0; s < SLOTS; s++) begin
      b_types[s] = 63;
      f_types[s] = 63;
    end

    // Reset values, then the fixed hand {0,13,26,39}
    run_span(0, 0, 2, 1'b0);
    card_types = {6'd39, 6'd26, 6'd13, 6'd0};
    run_line(480);
    for (int v = 399; v <= 446; v++) run_line(v);
    run_line(524);

    // Slot 2 empty; inputs scrambled each line to show the shadow copy holds
    for (int pass = 0; pass < 2; pass++) begin
      rand_types(1'b1, pass == 1);
      run_line(480);
      for (int v = (pass == 0) ? 399 : 430; v <= 446; v++) begin
        run_line(v);
        rand_types(1'b0, 1'b1);
      end
    end

    // Reset two cycles in the middle of a fetch (at k=50)
    rand_types(1'b0, 1'b0);
    run_line(480);
    run_span(399, 0, 2, 1'b1);
    run_span(399, 150, 335, 1'b1);
    run_span(399, 636, 690, 1'b1);
    run_span(399, 691, 692, 1'b0);
    run_span(399, 693, 775, 1'b1);
    run_line(400);
    run_line(480);
    for (int v = 400; v <= 403; v++) run_line(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
